// File: rtl/nn_mac_seq_if.sv
// Control and memory-read bundle for the neural-network MAC sequencer.
// The master side drives the sequencer; the slave side is the sequencer.
interface nn_mac_seq_if #(
  parameter int ACC_W = 50
);
  logic             start;
  logic             clr;
  logic             busy;
  logic             done;
  logic [9:0]       img_raddr;
  logic [7:0]       img_rdata;
  logic [15:0]      wt_raddr;
  logic [31:0]      wt_rdata;
  logic [3:0]       result;
  logic [ACC_W-1:0] best_score;

  modport master (
    output start, clr, img_rdata, wt_rdata,
    input  busy, done, img_raddr, wt_raddr, result, best_score
  );

  modport slave (
    input  start, clr, img_rdata, wt_rdata,
    output busy, done, img_raddr, wt_raddr, result, best_score
  );
endinterface

// File: rtl/nn_mac_seq.sv
// Sequential dot-product classifier: one MAC per cycle over every pixel for each
// output neuron, then a running signed argmax across neurons.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing pixel/weight reads for the current neuron
//   DRAIN | last read's product lands in the accumulator
//   CMP   | compare accumulator against best so far, step neuron
//   DONE  | one-cycle completion pulse
module nn_mac_seq #(
  parameter int N_PIX = 784,
  parameter int N_OUT = 10,
  parameter int ACC_W = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  nn_mac_seq_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CMP, S_DONE} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state, state_nxt;
  logic [9:0]              pix;
  logic [3:0]              neuron;
  logic [15:0]             wt_addr;
  logic                    valid;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] work_best;
  logic [3:0]              work_result;
  logic signed [40:0]      wt_ext, px_ext, prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    last_pix, last_neuron, better;

  assign wt_ext      = {{9{bus.wt_rdata[31]}}, bus.wt_rdata};
  assign px_ext      = {33'd0, bus.img_rdata};
  assign prod        = wt_ext * px_ext;
  assign prod_ext    = {{(ACC_W-41){prod[40]}}, prod};
  assign last_pix    = (pix == 10'(N_PIX - 1));
  assign last_neuron = (neuron == 4'(N_OUT - 1));
  assign better      = (acc > work_best);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (last_pix) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_CMP;
      S_CMP:   state_nxt = last_neuron ? S_DONE : S_RUN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.clr) state_nxt = S_IDLE;
  end

  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.done      = (state == S_DONE);
    bus.img_raddr = '0;
    bus.wt_raddr  = '0;
    if (state == S_RUN) begin
      bus.img_raddr = pix;
      bus.wt_raddr  = wt_addr;
    end
  end

  // Weight address runs continuously across neurons, so it always equals
  // neuron*N_PIX + pix without a multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix            <= '0;
      neuron         <= '0;
      wt_addr        <= '0;
      valid          <= 1'b0;
      acc            <= '0;
      work_best      <= '0;
      work_result    <= '0;
      bus.result     <= '0;
      bus.best_score <= '0;
    end else if (bus.clr) begin
      pix     <= '0;
      neuron  <= '0;
      wt_addr <= '0;
      valid   <= 1'b0;
      acc     <= '0;
    end else begin
      valid <= (state == S_RUN);
      if (valid) acc <= acc + prod_ext;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pix         <= '0;
            neuron      <= '0;
            wt_addr     <= '0;
            acc         <= '0;
            work_best   <= ACC_MIN;
            work_result <= '0;
          end
        end
        S_RUN: begin
          pix     <= pix + 10'd1;
          wt_addr <= wt_addr + 16'd1;
        end
        S_CMP: begin
          acc <= '0;
          pix <= '0;
          if (better) begin
            work_best   <= acc;
            work_result <= neuron;
          end
          // Visible outputs only change on a completed run, so an abort keeps the
          // previous answer.
          if (last_neuron) begin
            bus.result     <= better ? neuron : work_result;
            bus.best_score <= better ? acc : work_best;
          end else begin
            neuron <= neuron + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_mac_seq.sv
// Bench for nn_mac_seq: a small instance checked every cycle against a schedule and
// dot-product model, plus a default-size instance for the full-scale latency case.
module tb_nn_mac_seq;
  localparam int NP  = 4;
  localparam int NO  = 3;
  localparam int AW  = 50;
  localparam int LAT = NO * (NP + 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  nn_mac_seq_if #(.ACC_W(AW)) bus ();
  nn_mac_seq_if #(.ACC_W(50)) bus_d ();

  nn_mac_seq #(.N_PIX(NP), .N_OUT(NO), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  nn_mac_seq dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d.slave));

  logic [7:0]        img_mem [NP];
  logic signed [31:0] wt_mem [NP*NO];

  always @(posedge clk) begin
    bus.img_rdata <= img_mem[int'(bus.img_raddr) % NP];
    bus.wt_rdata  <= wt_mem[int'(bus.wt_raddr) % (NP*NO)];
  end

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: offset t counts cycles since the accepted start edge, -1 when idle.
  int     t = -1;
  int     exp_res = 0, pend_res = 0;
  longint exp_best = 0, pend_best = 0;
  bit     mon_en = 1'b0;
  int     done_seen = 0;

  function automatic void compute_pending();
    longint s;
    pend_res  = 0;
    pend_best = 0;
    for (int k = 0; k < NO; k++) begin
      s = 0;
      for (int p = 0; p < NP; p++)
        s += longint'(img_mem[p]) * longint'(wt_mem[k*NP + p]);
      if (k == 0 || s > pend_best) begin
        pend_best = s;
        pend_res  = k;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t        = -1;
      exp_res  = 0;
      exp_best = 0;
    end else begin
      if (t == LAT) begin
        exp_res  = pend_res;
        exp_best = pend_best;
        t        = -1;
      end else if (bus.clr) t = -1;
      else if (t >= 0) t++;
      else if (bus.start) begin
        t = 0;
        compute_pending();
      end
    end
  end

  always @(negedge clk) begin
    int  ph;
    bit  run;
    if (bus.done) done_seen++;
    if (mon_en) begin
      ph  = (t >= 0) ? t % (NP + 2) : 0;
      run = (t >= 0) && (t < LAT) && (ph < NP);
      check("busy", bus.busy, t >= 0);
      check("done", bus.done, t == LAT);
      check("img_raddr", bus.img_raddr, run ? ph : 0);
      check("wt_raddr", bus.wt_raddr, run ? (t / (NP + 2)) * NP + ph : 0);
      if (t < 0) begin
        check("result_hold", bus.result, exp_res);
        check("best_hold", $signed(bus.best_score), exp_best);
      end else if (t == LAT) begin
        check("result_done", bus.result, pend_res);
        check("best_done", $signed(bus.best_score), pend_best);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns at the negedge where done is seen.
  task automatic run_wait(input int bound, output int k);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0;
    @(negedge clk);
    while (!bus.done && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) check("timeout", bus.done, 1);
  endtask

  task automatic load(input int px[NP], input int w0, input int w1, input int w2, input bit per_pix,
                      input int wt[NP*NO]);
    for (int p = 0; p < NP; p++) img_mem[p] = 8'(px[p]);
    for (int i = 0; i < NP*NO; i++) begin
      if (per_pix) wt_mem[i] = 32'(wt[i]);
      else         wt_mem[i] = 32'((i / NP == 0) ? w0 : (i / NP == 1) ? w1 : w2);
    end
  endtask

  int img_a[NP]    = '{1, 2, 3, 4};
  int img_ff[NP]   = '{255, 255, 255, 255};
  int wt_a[NP*NO]  = '{1, 1, 1, 1, 0, 0, 0, 10, -5, 0, 0, 0};
  int wt_nil[NP*NO] = '{default: 0};

  initial begin
    int     k, d0;
    longint big_exp;
    bus.start     = 1'b0;
    bus.clr       = 1'b0;
    bus_d.start   = 1'b0;
    bus_d.clr     = 1'b0;
    bus_d.img_rdata = 8'hFF;
    bus_d.wt_rdata  = 32'h7FFF_FFFF;
    for (int p = 0; p < NP; p++) img_mem[p] = '0;
    for (int i = 0; i < NP*NO; i++) wt_mem[i] = '0;

    #2 rst_n = 1'b0;
    mon_en = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(1);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.result, 0);
    check("rst_best", $signed(bus.best_score), 0);

    load(img_a, 0, 0, 0, 1'b1, wt_a);
    run_wait(100, k);
    check("A_latency", k, 18);
    check("A_result", bus.result, 1);
    check("A_best", $signed(bus.best_score), 40);
    step(1);

    load(img_a, 2, 2, 2, 1'b0, wt_nil);
    run_wait(100, k);
    check("tie_latency", k, 18);
    check("tie_result", bus.result, 0);
    check("tie_best", $signed(bus.best_score), 20);
    step(1);

    load(img_ff, -1, -2, -3, 1'b0, wt_nil);
    run_wait(100, k);
    check("neg_result", bus.result, 0);
    check("neg_best", $signed(bus.best_score), -1020);
    step(1);

    // start held high across a whole run and past DONE
    load(img_a, 0, 0, 0, 1'b1, wt_a);
    bus.start = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("held_first_done", bus.done, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.done && k < 100);
    check("held_restart_gap", k, 20);
    @(posedge clk);
    #1 bus.start = 1'b0;
    step(2);
    check("held_result", bus.result, 1);
    check("held_best", $signed(bus.best_score), 40);

    // clr during neuron 1 of a tie run
    load(img_a, 2, 2, 2, 1'b0, wt_nil);
    d0 = done_seen;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(8);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    @(negedge clk);
    check("clr_busy", bus.busy, 0);
    check("clr_result", bus.result, 1);
    check("clr_best", $signed(bus.best_score), 40);
    step(30);
    check("clr_no_done", done_seen - d0, 0);
    run_wait(100, k);
    check("after_clr_latency", k, 18);
    check("after_clr_result", bus.result, 0);
    check("after_clr_best", $signed(bus.best_score), 20);
    step(1);

    // clr beats start in IDLE
    bus.clr   = 1'b1;
    bus.start = 1'b1;
    step(1);
    bus.clr   = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("clr_over_start", bus.busy, 0);
    step(1);

    // reset mid-run
    load(img_a, 0, 0, 0, 1'b1, wt_a);
    d0 = done_seen;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(5);
    rst_n = 1'b0;
    step(2);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_result", bus.result, 0);
    check("rstmid_best", $signed(bus.best_score), 0);
    check("rstmid_wt_raddr", bus.wt_raddr, 0);
    rst_n = 1'b1;
    step(30);
    check("rstmid_no_done", done_seen - d0, 0);
    run_wait(100, k);
    check("after_rst_latency", k, 18);
    check("after_rst_result", bus.result, 1);
    check("after_rst_best", $signed(bus.best_score), 40);
    step(1);

    // default-size instance, saturating operands
    big_exp = 64'd784 * 64'd255;
    big_exp = big_exp * 64'd2147483647;
    bus_d.start = 1'b1;
    @(posedge clk);
    #1 bus_d.start = 1'b0;
    k = 0;
    @(negedge clk);
    while (!bus_d.done && k < 9000) begin
      @(negedge clk);
      k++;
    end
    check("big_done_seen", bus_d.done, 1);
    check("big_latency", k, 7860);
    check("big_result", bus_d.result, 0);
    check("big_best", $signed(bus_d.best_score), big_exp);
    step(2);
    check("big_idle", bus_d.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
